// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide, DATA_LEN iterations.
// Optional MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiply operands finish straight from IDLE.
module mdu_sequencer #(
  parameter int DATA_LEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [2:0]          i_funct3,
  input  logic [DATA_LEN-1:0] i_op1,
  input  logic [DATA_LEN-1:0] i_op2,
  input  logic                i_kill,
  output logic                o_stall,
  output logic                o_busy,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_result
);

  localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          state;
  logic [2:0]          funct3;
  logic [DATA_LEN-1:0] acc;
  logic [DATA_LEN-1:0] mq;
  logic [DATA_LEN-1:0] opa;
  logic [DATA_LEN-1:0] result;
  logic [CNT_W-1:0]    count;
  logic                neg;

  logic                op1_signed;
  logic                op2_signed;
  logic                s1;
  logic                s2;
  logic                neg_in;
  logic [DATA_LEN-1:0] abs1;
  logic [DATA_LEN-1:0] abs2;

  // Operand magnitudes and the sign of the final result, captured at start.
  always_comb begin
    op1_signed = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                 (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    op2_signed = (i_funct3 == 3'b001) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    s1   = op1_signed & i_op1[DATA_LEN-1];
    s2   = op2_signed & i_op2[DATA_LEN-1];
    abs1 = s1 ? -i_op1 : i_op1;
    abs2 = s2 ? -i_op2 : i_op2;
    if (!i_funct3[2])
      neg_in = s1 ^ s2;
    else if (!i_funct3[1])
      neg_in = (s1 ^ s2) & (|i_op2);  // x/0 must stay all-ones whatever the sign of x
    else
      neg_in = s1;
  end

  logic [DATA_LEN:0]     mul_sum;
  logic [DATA_LEN:0]     div_shift;
  logic [DATA_LEN:0]     div_diff;
  logic                  div_ge;
  logic [2*DATA_LEN-1:0] prod;
  logic [2*DATA_LEN-1:0] prod_fix;
  logic [DATA_LEN-1:0]   fix_value;

  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opa} : {(DATA_LEN+1){1'b0}});
    div_shift = {acc, mq[DATA_LEN-1]};
    div_diff  = div_shift - {1'b0, opa};
    // The partial remainder is always below the divisor, so a borrow means "does not fit".
    div_ge    = ~div_diff[DATA_LEN];
    prod      = {acc, mq};
    prod_fix  = neg ? -prod : prod;
    case (funct3)
      3'b000:         fix_value = prod_fix[DATA_LEN-1:0];
      3'b100, 3'b101: fix_value = neg ? -mq : mq;
      3'b110, 3'b111: fix_value = neg ? -acc : acc;
      default:        fix_value = prod_fix[2*DATA_LEN-1:DATA_LEN];
    endcase
  end

  logic                early_hit;
  logic [DATA_LEN-1:0] early_value;

`ifdef MDU_EARLY_OUT_EN
  localparam logic [DATA_LEN-1:0] MIN_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

  always_comb begin
    early_hit   = 1'b0;
    early_value = '0;
    if (!i_funct3[2]) begin
      early_hit = (i_op1 == '0) | (i_op2 == '0);
    end else if (i_op2 == '0) begin
      early_hit   = 1'b1;
      early_value = i_funct3[1] ? i_op1 : '1;
    end else if (!i_funct3[0] && (i_op1 == MIN_NEG) && (&i_op2)) begin
      early_hit   = 1'b1;
      early_value = i_funct3[1] ? '0 : MIN_NEG;
    end
  end
`else
  assign early_hit   = 1'b0;
  assign early_value = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      funct3 <= '0;
      acc    <= '0;
      mq     <= '0;
      opa    <= '0;
      result <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else if (i_kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            funct3 <= i_funct3;
            neg    <= neg_in;
            acc    <= '0;
            count  <= CNT_W'(DATA_LEN - 1);
            // Divide: mq holds the dividend, opa the divisor. Multiply: mq multiplier, opa multiplicand.
            mq     <= i_funct3[2] ? abs1 : abs2;
            opa    <= i_funct3[2] ? abs2 : abs1;
            if (early_hit) begin
              result <= early_value;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (funct3[2]) begin
            acc <= div_ge ? div_diff[DATA_LEN-1:0] : div_shift[DATA_LEN-1:0];
            mq  <= {mq[DATA_LEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[DATA_LEN:1];
            mq  <= {mul_sum[0], mq[DATA_LEN-1:1]};
          end
          count <= count - CNT_W'(1);
          if (count == '0) state <= FIX;
        end
        FIX: begin
          result <= fix_value;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state != IDLE);
  assign o_valid  = (state == DONE) & ~i_kill;
  assign o_stall  = ~i_kill & (((state == IDLE) & i_start) | (state == CALC) | (state == FIX));
  assign o_result = result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomised and directed bench for mdu_sequencer against an arithmetic RV32M reference model.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  mdu_sequencer #(.DATA_LEN(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_funct3 (funct3),
    .i_op1    (op1),
    .i_op2    (op2),
    .i_kill   (kill),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension results computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MDU_EARLY_OUT_EN
    if (!f3[2] && (a == 32'h0 || b == 32'h0)) lat = 1;
    if (f3[2] && b == 32'h0) lat = 1;
    if (f3[2] && !f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) lat = 1;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFFFFFF;
      3:       v = 32'h80000000;
      4:       v = $urandom_range(0, 255);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Entered just after a negedge with the DUT idle; returns just after a negedge in the following IDLE cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] expv;
    logic [31:0] res;
    int lat;
    int seen;
    expv = ref_model(f3, a, b);
    lat  = exp_latency(f3, a, b);
    seen = -1;
    res  = 32'h0;
    start = 1'b1; funct3 = f3; op1 = a; op2 = b;
    for (int cyc = 0; cyc <= 60 && seen < 0; cyc++) begin
      #1;
      vectors++;
      if (stall !== 1'(cyc < lat)) begin
        miscompares++;
        $display("FAIL stall f3=%0d cyc=%0d: got %b expected %b", f3, cyc, stall, (cyc < lat));
      end
      if (valid === 1'b1) begin
        seen = cyc;
        res  = result;
      end else begin
        @(negedge clk);
      end
    end
    vectors++;
    if (seen !== lat) begin
      miscompares++;
      $display("FAIL latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, seen, lat);
    end
    vectors++;
    if (res !== expv) begin
      miscompares++;
      $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, expv);
    end
    if (!hold) start = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_done f3=%0d: got valid=%b busy=%b expected valid=0 busy=0", f3, valid, busy);
    end
    vectors++;
    if (result !== expv) begin
      miscompares++;
      $display("FAIL result_hold f3=%0d: got %h expected %h", f3, result, expv);
    end
    vectors++;
    if (stall !== hold) begin
      miscompares++;
      $display("FAIL idle_stall f3=%0d: got %b expected %b", f3, stall, hold);
    end
    $display("op f3=%0d a=%h b=%h -> result=%h latency=%0d", f3, a, b, res, seen);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op1 = 32'h0; op2 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b valid=%b stall=%b result=%h expected 0 0 0 00000000",
               busy, valid, stall, result);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'd6, 1'b0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 1'b0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd6, 32'hFFFFFFFB, 32'd0, 1'b0);
    run_op(3'd0, 32'd0, 32'h12345678, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++)
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b0);
  endtask

  task automatic test_kill();
    int vcount;
    @(negedge clk);
    #1;
    start = 1'b1; funct3 = 3'd4; op1 = $urandom; op2 = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_busy_before: got %b expected 1", busy);
    end
    kill = 1'b1; start = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_cycle: got stall=%b valid=%b expected 0 0", stall, valid);
    end
    @(negedge clk);
    #1;
    kill = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_idle: got busy=%b expected 0", busy);
    end
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid === 1'b1) vcount++;
    end
    vectors++;
    if (vcount !== 0) begin
      miscompares++;
      $display("FAIL kill_no_valid: got %0d pulses expected 0", vcount);
    end
    start = 1'b1; kill = 1'b1; funct3 = 3'd0; op1 = 32'd5; op2 = 32'd5;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_start_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_start_busy: got %b expected 0", busy);
    end
    run_op(3'd0, 32'd3, 32'd3, 1'b0);
  endtask

  task automatic test_rst_mid();
    int vcount;
    @(negedge clk);
    #1;
    start = 1'b1; funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got busy=%b valid=%b result=%h expected 0 0 00000000", busy, valid, result);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid === 1'b1) vcount++;
    end
    vectors++;
    if (vcount !== 0) begin
      miscompares++;
      $display("FAIL rst_no_valid: got %0d pulses expected 0", vcount);
    end
    run_op(3'd0, 32'd3, 32'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    #1;
    run_op(3'd0, 32'd11, 32'd13, 1'b1);
    run_op(3'd5, $urandom, 32'($urandom_range(1, 1000)), 1'b1);
    run_op(3'd1, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
